// File: rtl/logic_unit_pkg.sv
// Shared opcode encoding and default sizes for the pipelined logic unit.
// The optional reduction outputs of logic_unit_pipe are enabled by LOGIC_UNIT_REDUCE_EN.
package logic_unit_pkg;

  localparam int OP_W      = 3;
  localparam int DEF_WIDTH = 8;
  localparam int DEF_CNT_W = 16;

  typedef enum logic [OP_W-1:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XNOR = 3'd5,
    OP_NOT  = 3'd6,
    OP_ILL  = 3'd7
  } op_e;

endpackage

// File: rtl/logic_unit_core.sv
// Combinational opcode decode: bitwise result plus illegal-opcode flag.
module logic_unit_core
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             err
);

  always_comb begin
    y   = '0;
    err = 1'b0;
    case (op_e'(op))
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XNOR: y = ~(a ^ b);
      OP_NOT:  y = ~a;
      default: err = 1'b1;
    endcase
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// One-stage valid/ready logic unit with a saturating handshake counter.
// Defining LOGIC_UNIT_REDUCE_EN adds registered AND/OR/XOR reductions of y.
module logic_unit_pipe
  import logic_unit_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             err,
`ifdef LOGIC_UNIT_REDUCE_EN
  output logic             y_red_and,
  output logic             y_red_or,
  output logic             y_red_xor,
`endif
  output logic [CNT_W-1:0] op_count
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [WIDTH-1:0] w_y;
  logic             w_err;
  logic             w_accept;
  logic             w_hs;

  logic             r_valid_p0;
  logic [WIDTH-1:0] r_y_p0;
  logic             r_err_p0;
  logic [CNT_W-1:0] r_cnt;

  logic_unit_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .op  (op),
    .a   (a),
    .b   (b),
    .y   (w_y),
    .err (w_err)
  );

  assign in_ready = !r_valid_p0 || out_ready;
  assign w_accept = in_valid && in_ready;
  assign w_hs     = r_valid_p0 && out_ready;

  // Result stage: a simultaneous accept and handshake keeps the slot full with new data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid_p0 <= 1'b0;
      r_y_p0     <= '0;
      r_err_p0   <= 1'b0;
      r_cnt      <= '0;
    end else begin
      if (w_accept) begin
        r_valid_p0 <= 1'b1;
        r_y_p0     <= w_y;
        r_err_p0   <= w_err;
      end else if (w_hs) begin
        r_valid_p0 <= 1'b0;
      end
      if (w_hs && (r_cnt != CNT_MAX)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

`ifdef LOGIC_UNIT_REDUCE_EN
  logic r_red_and_p0;
  logic r_red_or_p0;
  logic r_red_xor_p0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_red_and_p0 <= 1'b0;
      r_red_or_p0  <= 1'b0;
      r_red_xor_p0 <= 1'b0;
    end else if (w_accept) begin
      r_red_and_p0 <= !w_err && (&w_y);
      r_red_or_p0  <= !w_err && (|w_y);
      r_red_xor_p0 <= !w_err && (^w_y);
    end
  end

  assign y_red_and = r_red_and_p0;
  assign y_red_or  = r_red_or_p0;
  assign y_red_xor = r_red_xor_p0;
`endif

  assign out_valid = r_valid_p0;
  assign y         = r_y_p0;
  assign err       = r_err_p0;
  assign op_count  = r_cnt;

endmodule

// File: doc/logic_unit_pipe.md
LOGIC_UNIT_PIPE -- requirements
Module: logic_unit_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the operand and result width in bits (1..64).
REQ-002 The block SHALL have parameter CNT_W, default 16, giving the completed-operation counter width in bits.
REQ-003 The block SHALL have the port clk, input, 1 bit, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have the port rst_n, input, 1 bit, a synchronous active-low reset.
REQ-005 The block SHALL have the port in_valid, input, 1 bit, meaning the operands and opcode are presented.
REQ-006 The block SHALL have the port in_ready, output, 1 bit, meaning the block accepts input this cycle.
REQ-007 The block SHALL have the port op, input, 3 bits, the opcode.
REQ-008 The block SHALL have the ports a and b, inputs, WIDTH bits each, the operands.
REQ-009 The block SHALL have the port out_valid, output, 1 bit, meaning the result is held.
REQ-010 The block SHALL have the port out_ready, input, 1 bit, meaning the consumer takes the result.
REQ-011 The block SHALL have the port y, output, WIDTH bits, the registered result.
REQ-012 The block SHALL have the port err, output, 1 bit, the registered illegal-opcode flag for the held result.
REQ-013 The block SHALL have the port op_count, output, CNT_W bits, the count of completed output handshakes.

Function
REQ-014 The opcodes SHALL be bitwise over WIDTH: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 NOT a (b ignored).
REQ-015 Opcode 7 SHALL be illegal: it is accepted normally, with y=0 and err=1; all legal opcodes give err=0.
REQ-016 Input acceptance SHALL occur when in_valid && in_ready are both high on a rising edge.
REQ-017 Output handshake SHALL occur when out_valid && out_ready are both high on a rising edge.
REQ-018 in_ready SHALL equal !out_valid || out_ready, combinationally; no other input-to-output combinational path exists.
REQ-019 Latency SHALL be 1 cycle: y, err and out_valid update on the edge that accepts the input.
REQ-020 Throughput SHALL be 1 operation per cycle while out_ready is held high.
REQ-021 On acceptance, out_valid SHALL become 1; on an output handshake without acceptance, out_valid SHALL become 0.
REQ-022 When acceptance and output handshake happen on the same edge, the new result SHALL replace the old one, out_valid SHALL stay 1, and op_count SHALL still increment.
REQ-023 While out_valid=1 and out_ready=0, y and err SHALL be held stable and no input is accepted.
REQ-024 y and err SHALL hold their last values when out_valid=0; their contents are don't-care for consumers.
REQ-025 op_count SHALL increment by 1 per output handshake and saturate at 2^CNT_W-1; it never wraps.
REQ-026 in_valid=1 while in_ready=0 SHALL have no effect; the producer is responsible for holding its data.

Reset
REQ-027 When rst_n=0 at a rising edge, the block SHALL set out_valid=0, y=0, err=0 and op_count=0.
REQ-028 A reset mid-operation SHALL discard the held result without any handshake, and no op_count increment occurs.
REQ-029 in_ready SHALL be 1 in the first cycle after reset is released.

Configuration
REQ-030 The block SHALL compile three extra registered output ports when macro LOGIC_UNIT_REDUCE_EN is defined: y_red_and, y_red_or and y_red_xor, each 1 bit, the AND, OR and XOR reductions of the new y.
REQ-031 The reduction outputs SHALL load on the same edge as y, reset to 0, and be forced to 0 for opcode 7.
REQ-032 Without LOGIC_UNIT_REDUCE_EN, the reduction ports and logic SHALL be absent; all other behaviour is identical.

Structure
REQ-033 Package logic_unit_pkg SHALL hold the op_e enum (OP_AND..OP_NOT, OP_ILL=7), the opcode width constant 3, and the default WIDTH and CNT_W.
REQ-034 The combinational opcode decode SHALL be the sub-module logic_unit_core (inputs op, a, b; outputs y, err), instantiated once; handshake, registers and counter stay in logic_unit_pipe.

Verification
REQ-035 The bench SHALL cover this scenario with WIDTH=8 and out_ready=1: a=8'hF0, b=8'hCC, ops 0..6 on back-to-back cycles -> y = C0, FC, 3C, 3F, 03, C3, 0F one cycle after each input, err=0, op_count=7.
REQ-036 The bench SHALL cover this scenario: op=7, a=8'hFF, b=8'hFF -> y=00, err=1, out_valid=1, and op_count increments on the handshake.
REQ-037 The bench SHALL cover this scenario: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, and y is held at the first result for all 3 cycles; raising out_ready gives the handshake and the next input is accepted on the same edge.
REQ-038 The bench SHALL cover this scenario: CNT_W=2 with 5 handshakes -> op_count reads 3 and stays at 3.
REQ-039 The bench SHALL cover this scenario: rst_n=0 for one cycle while out_valid=1 and out_ready=0 -> next cycle out_valid=0, y=0, op_count=0, in_ready=1.
REQ-040 The bench SHALL cover this scenario with LOGIC_UNIT_REDUCE_EN defined: op=0, a=8'hFF, b=8'hFF -> y_red_and=1, y_red_or=1, y_red_xor=0; op=2 with the same a and b -> y_red_and=0, y_red_or=0, y_red_xor=0.
